bcd_timer: RTL and testbench

Parametrised BCD stopwatch/countdown timer: N decimal digits, configurable tick prescaler, up or down counting, per-digit preset editing via three push-buttons. Next generation of the lab 4-digit stopwatch: it drives the board's 7-segment displays through the existing `hex` decoder and replaces the fixed 4-digit, up-only design.

---
 rtl/timer_pkg.sv | 13 +
 rtl/button_sync.sv | 28 ++
 rtl/hex.sv | 31 +++
 rtl/bcd_timer.sv | 182 ++++++++++++++++++
 tb/tb_bcd_timer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding and BCD limits for the bcd_timer slice.
// Pure declarations; no logic.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EDIT = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/button_sync.sv
// Active-low async push-button to one-cycle press pulse: two sync flops plus an edge flop.
// Pulse appears two edges after the low level is first sampled; no debounce.
module button_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic pressed_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= ~btn_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pressed_o = sync_q & ~prev_q;

endmodule

// File: rtl/hex.sv
// Nibble to 7-segment decoder, active-high segments, bit 0 = segment a ... bit 6 = segment g.
// Purely combinational.
module hex (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b0000000;
        case (bcd_i)
            4'h0: seg_o = 7'b0111111;
            4'h1: seg_o = 7'b0000110;
            4'h2: seg_o = 7'b1011011;
            4'h3: seg_o = 7'b1001111;
            4'h4: seg_o = 7'b1100110;
            4'h5: seg_o = 7'b1101101;
            4'h6: seg_o = 7'b1111101;
            4'h7: seg_o = 7'b0000111;
            4'h8: seg_o = 7'b1111111;
            4'h9: seg_o = 7'b1101111;
            4'hA: seg_o = 7'b1110111;
            4'hB: seg_o = 7'b1111100;
            4'hC: seg_o = 7'b0111001;
            4'hD: seg_o = 7'b1011110;
            4'hE: seg_o = 7'b1111001;
            4'hF: seg_o = 7'b1110001;
            default: seg_o = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/bcd_timer.sv
// N-digit BCD stopwatch / countdown with prescaled tick and per-digit preset editing.
// Digits update on the tick edge; button actions land one edge after their press pulse.
module bcd_timer
    import timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1_000_000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic                      clk100_i,
    input  logic                      rst_i,
    input  logic                      start_stop_i,
    input  logic                      set_i,
    input  logic                      change_i,
    input  logic                      dir_i,
    output logic [4*DIGITS-1:0]       digits_o,
    output logic [7*DIGITS-1:0]       hex_o,
    output logic                      running_o,
    output logic                      edit_o,
    output logic [$clog2(DIGITS)-1:0] edit_digit_o,
    output logic                      expired_o
);

    localparam int               IDX_W      = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] PRESC_TOP  = CNT_W'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic [CNT_W-1:0]    presc_q, presc_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [IDX_W-1:0]    edit_q, edit_d;
    logic                expired_q, expired_d;

    logic                start_p;
    logic                set_p;
    logic                change_p;
    logic                tick;
    logic                expire;
    logic                start_blocked;
    logic [DIGITS-1:0]   carry;
    logic [DIGITS-1:0]   borrow;
    logic [DIGITS-1:0]   at_max;
    logic [DIGITS-1:0]   at_zero;
    logic [4*DIGITS-1:0] count_nx;
    logic [4*DIGITS-1:0] edit_nx;

    button_sync u_start_sync (
        .clk_i    (clk100_i),
        .rst_i    (rst_i),
        .btn_n_i  (start_stop_i),
        .pressed_o(start_p)
    );

    button_sync u_set_sync (
        .clk_i    (clk100_i),
        .rst_i    (rst_i),
        .btn_n_i  (set_i),
        .pressed_o(set_p)
    );

    button_sync u_change_sync (
        .clk_i    (clk100_i),
        .rst_i    (rst_i),
        .btn_n_i  (change_i),
        .pressed_o(change_p)
    );

    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_TOP);
    assign carry[0]  = tick & ~dir_q;
    assign borrow[0] = tick & dir_q;

    // Ripple carry/borrow chain; each digit also precomputes its edit-increment value.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] cur;

        assign cur        = digits_q[4*k +: 4];
        assign at_max[k]  = (cur == BCD_MAX);
        assign at_zero[k] = (cur == 4'd0);

        if (k > 0) begin : g_chain
            assign carry[k]  = carry[k-1] & at_max[k-1];
            assign borrow[k] = borrow[k-1] & at_zero[k-1];
        end

        assign count_nx[4*k +: 4] = carry[k]  ? (at_max[k]  ? 4'd0    : cur + 4'd1) :
                                    borrow[k] ? (at_zero[k] ? BCD_MAX : cur - 4'd1) :
                                                cur;

        assign edit_nx[4*k +: 4] = (edit_q == IDX_W'(k)) ? (at_max[k] ? 4'd0 : cur + 4'd1) : cur;

        hex u_hex (
            .bcd_i(cur),
            .seg_o(hex_o[7*k +: 7])
        );
    end

    assign expire        = tick && dir_q && (count_nx == '0);
    assign start_blocked = dir_i && (digits_q == '0);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        digits_d  = digits_q;
        edit_d    = edit_q;
        expired_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (set_p) begin
                    state_d = ST_EDIT;
                    edit_d  = '0;
                end else if (start_p && !start_blocked) begin
                    state_d = ST_RUN;
                    dir_d   = dir_i;
                end
            end
            ST_RUN: begin
                if (set_p) begin
                    state_d  = ST_IDLE;
                    digits_d = '0;
                end else begin
                    digits_d = count_nx;
                    if (expire) begin
                        state_d   = ST_IDLE;
                        expired_d = 1'b1;
                    end else if (start_p) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EDIT: begin
                if (change_p) begin
                    digits_d = edit_nx;
                end
                if (set_p) begin
                    if (edit_q == LAST_DIGIT) begin
                        state_d = ST_IDLE;
                        edit_d  = '0;
                    end else begin
                        edit_d = edit_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only advance while staying in RUN, so every run segment starts a full tick period.
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
        end else begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            presc_q   <= '0;
            digits_q  <= '0;
            edit_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            presc_q   <= presc_d;
            digits_q  <= digits_d;
            edit_q    <= edit_d;
            expired_q <= expired_d;
        end
    end

    assign digits_o     = digits_q;
    assign running_o    = (state_q == ST_RUN);
    assign edit_o       = (state_q == ST_EDIT);
    assign edit_digit_o = edit_q;
    assign expired_o    = expired_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Randomized bench for bcd_timer (3 digits, tick every 4 cycles) against an integer-valued reference.
// The reference tracks the displayed value as a plain number 0..999 and derives digits by division.
module tb_bcd_timer;

    localparam int DIGITS   = 3;
    localparam int TICK_DIV = 4;
    localparam int MODV     = 1000;

    logic        clk100_i     = 1'b0;
    logic        rst_i        = 1'b1;
    logic        start_stop_i = 1'b1;
    logic        set_i        = 1'b1;
    logic        change_i     = 1'b1;
    logic        dir_i        = 1'b0;
    logic [11:0] digits_o;
    logic [20:0] hex_o;
    logic        running_o;
    logic        edit_o;
    logic [1:0]  edit_digit_o;
    logic        expired_o;

    int checks    = 0;
    int errors    = 0;
    int model_val = 0;

    always #5 clk100_i = ~clk100_i;

    bcd_timer #(
        .DIGITS  (DIGITS),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk100_i    (clk100_i),
        .rst_i       (rst_i),
        .start_stop_i(start_stop_i),
        .set_i       (set_i),
        .change_i    (change_i),
        .dir_i       (dir_i),
        .digits_o    (digits_o),
        .hex_o       (hex_o),
        .running_o   (running_o),
        .edit_o      (edit_o),
        .edit_digit_o(edit_digit_o),
        .expired_o   (expired_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'((v % 10));
        r[7:4]  = 4'(((v / 10) % 10));
        r[11:8] = 4'(((v / 100) % 10));
        return r;
    endfunction

    function automatic logic [6:0] seg(input int d);
        logic [6:0] table_q [10];
        table_q = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return table_q[d];
    endfunction

    function automatic logic [20:0] exp_hex(input int v);
        return {seg((v / 100) % 10), seg((v / 10) % 10), seg(v % 10)};
    endfunction

    task automatic drive(input int which, input logic lvl);
        case (which)
            0: start_stop_i = lvl;
            1: set_i        = lvl;
            default: change_i = lvl;
        endcase
    endtask

    task automatic press(input int which);
        @(negedge clk100_i);
        drive(which, 1'b0);
        repeat (3) @(negedge clk100_i);
        drive(which, 1'b1);
        repeat (4) @(negedge clk100_i);
    endtask

    task automatic do_reset();
        @(negedge clk100_i);
        rst_i        = 1'b1;
        start_stop_i = 1'b1;
        set_i        = 1'b1;
        change_i     = 1'b1;
        repeat (2) @(negedge clk100_i);
        rst_i     = 1'b0;
        model_val = 0;
        repeat (2) @(negedge clk100_i);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_digits"}, digits_o, to_bcd(model_val));
        check({tag, "_hex"}, hex_o, exp_hex(model_val));
        check({tag, "_running"}, running_o, 0);
        check({tag, "_edit"}, edit_o, 0);
    endtask

    // Enter EDIT, bump each digit c[k] times, advance through all digits back to IDLE.
    task automatic edit_task(input int c0, input int c1, input int c2);
        int c [3];
        int pw [3];
        int dk;
        c  = '{c0, c1, c2};
        pw = '{1, 10, 100};
        press(1);
        check("edit_enter", edit_o, 1);
        check("edit_idx0", edit_digit_o, 0);
        for (int k = 0; k < DIGITS; k++) begin
            repeat (c[k]) press(2);
            dk        = (model_val / pw[k]) % 10;
            model_val = model_val - dk * pw[k] + ((dk + c[k]) % 10) * pw[k];
            check("edit_digits", digits_o, to_bcd(model_val));
            press(1);
            if (k < DIGITS - 1) begin
                check("edit_stay", edit_o, 1);
                check("edit_idx", edit_digit_o, k + 1);
            end
        end
        check_idle("edit_exit");
    endtask

    // Start a run and follow it cycle by cycle until it stops (button, clear or expiry).
    task automatic run_seq(input bit d, input int stop_at, input bit use_set);
        int  v0;
        int  ticks;
        int  exp_v;
        int  j;
        bit  fell;
        bit  expect_exp;
        bit  legit;
        v0    = model_val;
        fell  = 1'b0;
        dir_i = d;
        @(negedge clk100_i);
        start_stop_i = 1'b0;
        j = 0;
        while (!running_o && j < 10) begin
            @(negedge clk100_i);
            j++;
            if (j == 3) start_stop_i = 1'b1;
        end
        start_stop_i = 1'b1;
        if (!running_o) begin
            check("run_enter", running_o, 1);
            return;
        end
        dir_i = 1'($urandom_range(0, 1));
        j = 0;
        while (j < 20000 && !fell) begin
            if (j > 0) @(negedge clk100_i);
            if (j == stop_at) begin
                if (use_set) set_i = 1'b0;
                else start_stop_i = 1'b0;
            end
            if (j == stop_at + 3) begin
                set_i        = 1'b1;
                start_stop_i = 1'b1;
            end
            ticks      = j / TICK_DIV;
            expect_exp = d && (j > 0) && (j % TICK_DIV == 0) && (ticks == v0);
            exp_v      = d ? v0 - ticks : (v0 + ticks) % MODV;
            if (exp_v < 0) exp_v = 0;
            if (!running_o) begin
                legit = expect_exp || (stop_at >= 0 && j > stop_at && j <= stop_at + 6);
                check("stop_timing", legit, 1);
                if (!expect_exp && use_set && stop_at >= 0 && j > stop_at) exp_v = 0;
                check("stop_digits", digits_o, to_bcd(exp_v));
                check("stop_hex", hex_o, exp_hex(exp_v));
                check("stop_expired", expired_o, expect_exp);
                model_val = exp_v;
                fell      = 1'b1;
            end else begin
                if (expect_exp) check("expiry_exit", running_o, 0);
                check("run_digits", digits_o, to_bcd(exp_v));
                check("run_expired", expired_o, 0);
                j++;
            end
        end
        set_i        = 1'b1;
        start_stop_i = 1'b1;
        if (!fell) begin
            check("run_exit", running_o, 0);
            return;
        end
        @(negedge clk100_i);
        check("expired_once", expired_o, 0);
        check("stay_idle", running_o, 0);
        repeat (4) @(negedge clk100_i);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int v;
        int sa;
        bit d;
        bit us;

        do_reset();
        check_idle("reset");
        check("reset_edit_idx", edit_digit_o, 0);
        check("reset_expired", expired_o, 0);

        // Full wrap of the up counter.
        run_seq(1'b0, 4 * 1000 + 6, 1'b0);

        // Edit to 012 then count down to expiry.
        do_reset();
        edit_task(2, 1, 0);
        check("edit_012", digits_o, 12'h012);
        run_seq(1'b1, -1, 1'b0);
        check("expired_at_zero", digits_o, 12'h000);

        // Pause then resume: the resumed run must tick a full period after entry.
        do_reset();
        run_seq(1'b0, 6, 1'b0);
        run_seq(1'b0, 20, 1'b0);

        // Clear while running from 057.
        do_reset();
        edit_task(7, 5, 0);
        run_seq(1'b0, 4, 1'b1);
        check("clear_zero", digits_o, 12'h000);

        // Simultaneous set and start_stop from IDLE: set wins.
        do_reset();
        @(negedge clk100_i);
        set_i        = 1'b0;
        start_stop_i = 1'b0;
        repeat (3) @(negedge clk100_i);
        set_i        = 1'b1;
        start_stop_i = 1'b1;
        repeat (4) @(negedge clk100_i);
        check("simul_edit", edit_o, 1);
        check("simul_idx", edit_digit_o, 0);
        check("simul_running", running_o, 0);
        repeat (3) press(1);
        check_idle("simul_exit");

        // Asynchronous reset mid-run at 034, then a refused countdown from 000.
        do_reset();
        edit_task(4, 3, 0);
        dir_i = 1'b0;
        @(negedge clk100_i);
        start_stop_i = 1'b0;
        for (int i = 0; i < 10 && !running_o; i++) @(negedge clk100_i);
        check("rst_run_entered", running_o, 1);
        check("rst_run_value", digits_o, 12'h034);
        @(posedge clk100_i);
        #2 rst_i = 1'b1;
        #1;
        model_val = 0;
        check("async_rst_digits", digits_o, 12'h000);
        check("async_rst_hex", hex_o, exp_hex(0));
        check("async_rst_running", running_o, 0);
        check("async_rst_edit", edit_o, 0);
        check("async_rst_expired", expired_o, 0);
        @(negedge clk100_i);
        start_stop_i = 1'b1;
        rst_i        = 1'b0;
        repeat (2) @(negedge clk100_i);
        dir_i = 1'b1;
        start_stop_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk100_i);
            if (i == 3) start_stop_i = 1'b1;
            check("zero_start_running", running_o, 0);
            check("zero_start_expired", expired_o, 0);
        end
        check_idle("zero_start");

        // Randomized presets, directions and stop points.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            edit_task(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            v  = model_val;
            d  = 1'($urandom_range(0, 1));
            us = 1'($urandom_range(0, 1));
            if (d && v == 0) d = 1'b0;
            if (d) begin
                if (v > 10 && us) begin
                    sa = int'($urandom_range(4, 4 * v - 20));
                    us = 1'($urandom_range(0, 1));
                end else begin
                    sa = -1;
                    us = 1'b0;
                end
            end else begin
                sa = int'($urandom_range(4, 80));
            end
            run_seq(d, sa, us);
            check_idle("rand_after");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
